// File: rtl/gesture_pkg.sv
// -----------------------------------------------------------------------------
// gesture_pkg
// Shared definitions for the gesture interface (encoder and decoder sides).
//  - Gesture codes driven on the 8-bit gesture bus.
//  - Finger channel indices (thumb..pinky).
//  - Encoder FSM state type.
//  - gesture_of(): maps a 5-bit bent vector {pinky,ring,middle,index,thumb}
//    to a gesture code.
// -----------------------------------------------------------------------------
package gesture_pkg;

    localparam logic [7:0] GEST_NONE     = 8'h00;
    localparam logic [7:0] GEST_ROCK     = 8'h01;
    localparam logic [7:0] GEST_PAPER    = 8'h02;
    localparam logic [7:0] GEST_SCISSORS = 8'h03;

    localparam int FINGER_THUMB  = 0;
    localparam int FINGER_INDEX  = 1;
    localparam int FINGER_MIDDLE = 2;
    localparam int FINGER_RING   = 3;
    localparam int FINGER_PINKY  = 4;
    localparam int NUM_FINGERS   = 5;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        CLASSIFY = 2'd1,
        UPDATE   = 2'd2
    } enc_state_t;

    function automatic logic [7:0] gesture_of(input logic [4:0] bent);
        logic [7:0] code;
        case (bent)
            5'b11111: code = GEST_ROCK;
            5'b00000: code = GEST_PAPER;
            5'b11001: code = GEST_SCISSORS;   // thumb, ring, pinky bent
            default:  code = GEST_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/finger_hysteresis.sv
// -----------------------------------------------------------------------------
// finger_hysteresis
// Bent/extended classifier for one finger with a hold band between BEND_LO
// and BEND_HI (both thresholds themselves are inside the hold band).
// Ports:
//  clk    in   1       system clock
//  reset  in   1       synchronous active-high reset (bent -> 0)
//  en     in   1       evaluate data this cycle
//  data   in   DATA_W  unsigned ADC sample
//  bent   out  1       registered bent state
// -----------------------------------------------------------------------------
module finger_hysteresis #(
    parameter int DATA_W  = 12,
    parameter int BEND_HI = 2600,
    parameter int BEND_LO = 1800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic              bent
);

    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(BEND_HI);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(BEND_LO);

    logic bent_d;
    logic bent_q;

    // Next bent state: only leave the current state when outside the hold band
    always_comb begin
        bent_d = bent_q;
        if (en) begin
            if (data > HI_TH) begin
                bent_d = 1'b1;
            end else if (data < LO_TH) begin
                bent_d = 1'b0;
            end else begin
                bent_d = bent_q;
            end
        end else begin
            bent_d = bent_q;
        end
    end

    // Bent state register
    always_ff @(posedge clk) begin
        if (reset) begin
            bent_q <= 1'b0;
        end else begin
            bent_q <= bent_d;
        end
    end

    assign bent = bent_q;

endmodule

// File: rtl/gesture_encoder.sv
// -----------------------------------------------------------------------------
// gesture_encoder
// Transmit side of the gesture interface. Collects a five-channel flex-sensor
// frame, classifies each finger with hysteresis, maps the pattern to a gesture
// code and debounces it over STABLE_FRAMES consecutive frames.
// Ports:
//  clk            in   1       system clock
//  reset          in   1       synchronous active-high reset
//  sample_valid   in   1       sample offered (accepted with sample_ready)
//  sample_ch      in   3       channel 0..4 = thumb..pinky, 5..7 dropped
//  sample_data    in   DATA_W  ADC reading for sample_ch
//  sample_ready   out  1       sample can be accepted this cycle
//  finger_bent    out  5       per-finger hysteresis state
//  gesture        out  8       committed gesture code
//  gesture_valid  out  1       one-cycle pulse when gesture changes
//  frame_err      out  1       one-cycle pulse when a partial frame is dropped
// -----------------------------------------------------------------------------
module gesture_encoder
    import gesture_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int BEND_HI       = 2600,
    parameter int BEND_LO       = 1800,
    parameter int STABLE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [2:0]        sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic [4:0]        finger_bent,
    output logic [7:0]        gesture,
    output logic              gesture_valid,
    output logic              frame_err
);

    localparam int               CNT_W      = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    enc_state_t        state_q, state_d;
    logic              sample_ready_q, sample_ready_d;
    logic [3:0]        seen_q, seen_d;
    logic [DATA_W-1:0] slot_q [NUM_FINGERS];
    logic [DATA_W-1:0] slot_d [NUM_FINGERS];
    logic [7:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        gesture_q, gesture_d;
    logic              gesture_valid_q, gesture_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              accept_s;
    logic              pinky_s;
    logic              frame_done_s;
    logic              frame_bad_s;
    logic              hyst_en_s;
    logic              update_s;
    logic [4:0]        finger_bent_s;
    logic [7:0]        class_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // sample_ready is registered, so accepts can only happen in COLLECT
    assign accept_s     = sample_valid & sample_ready_q;
    assign pinky_s      = accept_s && (sample_ch == 3'(FINGER_PINKY));
    assign frame_done_s = pinky_s && (seen_q == 4'b1111);
    assign frame_bad_s  = pinky_s && (seen_q != 4'b1111);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (frame_done_s) begin
                    state_d = CLASSIFY;
                end else begin
                    state_d = COLLECT;
                end
            end
            CLASSIFY: state_d = UPDATE;
            UPDATE:   state_d = COLLECT;
            default:  state_d = COLLECT;
        endcase
    end

    // FSM output decode; ready is computed one cycle ahead and registered
    always_comb begin
        sample_ready_d = (state_d == COLLECT);
        hyst_en_s      = (state_q == CLASSIFY);
        update_s       = (state_q == UPDATE);
    end

    // Sample slots, seen mask and frame error detection
    always_comb begin
        seen_d      = seen_q;
        frame_err_d = 1'b0;
        for (int i = 0; i < NUM_FINGERS; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (update_s) begin
            seen_d = 4'b0000;
        end else if (accept_s) begin
            if (sample_ch <= 3'(FINGER_PINKY)) begin
                slot_d[sample_ch] = sample_data;
            end else begin
                slot_d[0] = slot_q[0];
            end
            if (sample_ch < 3'(FINGER_PINKY)) begin
                seen_d[sample_ch[1:0]] = 1'b1;
            end else if (frame_bad_s) begin
                seen_d      = 4'b0000;
                frame_err_d = 1'b1;
            end else begin
                seen_d = seen_q;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // Debounce: count consecutive identical classifications, commit on change
    always_comb begin
        class_s         = gesture_of(finger_bent_s);
        cand_d          = cand_q;
        cnt_d           = cnt_q;
        cnt_next_s      = cnt_q;
        gesture_d       = gesture_q;
        gesture_valid_d = 1'b0;
        if (update_s) begin
            if (class_s == cand_q) begin
                // saturate so a long-held gesture never wraps back to 0
                if (cnt_q == STABLE_CNT) begin
                    cnt_next_s = cnt_q;
                end else begin
                    cnt_next_s = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_next_s = CNT_ONE;
            end
            cand_d = class_s;
            cnt_d  = cnt_next_s;
            if ((cnt_next_s == STABLE_CNT) && (class_s != gesture_q)) begin
                gesture_d       = class_s;
                gesture_valid_d = 1'b1;
            end else begin
                gesture_d = gesture_q;
            end
        end else begin
            cand_d = cand_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_ready_q  <= 1'b0;
            seen_q          <= 4'b0000;
            cand_q          <= GEST_NONE;
            cnt_q           <= '0;
            gesture_q       <= GEST_NONE;
            gesture_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            for (int i = 0; i < NUM_FINGERS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            sample_ready_q  <= sample_ready_d;
            seen_q          <= seen_d;
            cand_q          <= cand_d;
            cnt_q           <= cnt_d;
            gesture_q       <= gesture_d;
            gesture_valid_q <= gesture_valid_d;
            frame_err_q     <= frame_err_d;
            for (int i = 0; i < NUM_FINGERS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_FINGERS; g++) begin : g_finger
        finger_hysteresis #(
            .DATA_W  (DATA_W),
            .BEND_HI (BEND_HI),
            .BEND_LO (BEND_LO)
        ) u_hyst (
            .clk   (clk),
            .reset (reset),
            .en    (hyst_en_s),
            .data  (slot_q[g]),
            .bent  (finger_bent_s[g])
        );
    end

    assign sample_ready  = sample_ready_q;
    assign finger_bent   = finger_bent_s;
    assign gesture       = gesture_q;
    assign gesture_valid = gesture_valid_q;
    assign frame_err     = frame_err_q;

endmodule
